// File: rtl/tri_raster_scanner.sv
// tri_raster_scanner: accepts one screen-space triangle over valid/ready,
// clamps its bounding box to the screen, walks the box in raster order one
// pixel per cycle through a tri_point_tester and streams covered pixels out.
// Optional build macro TRI_RASTER_STATS_EN adds stat_tested / stat_drawn.
//
// Handshake semantics (both ports): a transfer happens on a rising edge where
// valid && ready are both high. A producer holding valid keeps its payload
// stable until the transfer; valid never drops without a transfer (reset
// excepted). Ready may depend on state only, never on the partner's valid.

package tri_raster_pkg;
    localparam int COORD_W = 16;
    typedef logic signed [COORD_W-1:0] coord_t;
    typedef struct packed {
        coord_t x;
        coord_t y;
    } point_t;
    typedef struct packed {
        point_t a;
        point_t b;
        point_t c;
    } triangle_t;
endpackage

// Combinational coverage test: a pixel is covered when the triangle has
// strictly positive (counter-clockwise) area and the pixel lies on or inside
// all three edges. Degenerate or clockwise triangles cover nothing.
module tri_point_tester
    import tri_raster_pkg::*;
(
    input  triangle_t tri_in,
    input  point_t    pt,
    output logic      point_in_tri
);
    // Wide enough for a difference of products of 17-bit deltas.
    localparam int EW = 2 * COORD_W + 4;

    function automatic logic signed [EW-1:0] sext(input coord_t v);
        return {{(EW - COORD_W){v[COORD_W-1]}}, v};
    endfunction

    // Signed area term of (p0 -> p1) against q; >= 0 means q is left of or on the edge.
    function automatic logic signed [EW-1:0] edge_fn(input point_t p0, input point_t p1,
                                                     input point_t q);
        logic signed [EW-1:0] dx1;
        logic signed [EW-1:0] dy1;
        logic signed [EW-1:0] dx2;
        logic signed [EW-1:0] dy2;
        dx1 = sext(p1.x) - sext(p0.x);
        dy1 = sext(p1.y) - sext(p0.y);
        dx2 = sext(q.x) - sext(p0.x);
        dy2 = sext(q.y) - sext(p0.y);
        return dx1 * dy2 - dy1 * dx2;
    endfunction

    logic signed [EW-1:0] area2;
    logic signed [EW-1:0] e_ab;
    logic signed [EW-1:0] e_bc;
    logic signed [EW-1:0] e_ca;

    // Edge functions and orientation, then the inclusive inside test.
    always_comb begin
        area2 = edge_fn(tri_in.a, tri_in.b, tri_in.c);
        e_ab  = edge_fn(tri_in.a, tri_in.b, pt);
        e_bc  = edge_fn(tri_in.b, tri_in.c, pt);
        e_ca  = edge_fn(tri_in.c, tri_in.a, pt);
        point_in_tri = !area2[EW-1] && (area2 != '0) &&
                       !e_ab[EW-1] && !e_bc[EW-1] && !e_ca[EW-1];
    end
endmodule

module tri_raster_scanner
    import tri_raster_pkg::*;
#(
    parameter int SCREEN_W = 640,
    parameter int SCREEN_H = 480
) (
    input  logic        clk,
    input  logic        rst,
    input  triangle_t   in_tri,
    input  logic        in_valid,
    output logic        in_ready,
    output point_t      out_pt,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        done,
`ifdef TRI_RASTER_STATS_EN
    output logic [31:0] stat_tested,
    output logic [31:0] stat_drawn,
`endif
    output logic [1:0]  dbg_state
);
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_SCAN  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam coord_t ZERO = coord_t'(0);
    localparam coord_t ONE  = coord_t'(1);
    localparam coord_t X_HI = coord_t'(SCREEN_W - 1);
    localparam coord_t Y_HI = coord_t'(SCREEN_H - 1);

    function automatic coord_t smin(input coord_t p, input coord_t q);
        return (p < q) ? p : q;
    endfunction

    function automatic coord_t smax(input coord_t p, input coord_t q);
        return (p > q) ? p : q;
    endfunction

    state_t    state;
    state_t    state_next;
    triangle_t tri_q;
    coord_t    xmin, xmax, ymin, ymax;
    coord_t    cx, cy;
    logic      scan_last;   // last pixel of the box has been advanced past

    coord_t    lo_x, hi_x, lo_y, hi_y;
    coord_t    bx_min, bx_max, by_min, by_max;
    logic      box_empty;
    logic      accept;
    logic      out_free;
    logic      advance;
    logic      last_px;
    logic      hit;
    point_t    cursor;

    assign cursor = '{x: cx, y: cy};

    tri_point_tester u_tester (
        .tri_in       (tri_q),
        .pt           (cursor),
        .point_in_tri (hit)
    );

    // Bounding box of the registered triangle, clamped to the screen.
    always_comb begin
        lo_x = smin(smin(tri_q.a.x, tri_q.b.x), tri_q.c.x);
        hi_x = smax(smax(tri_q.a.x, tri_q.b.x), tri_q.c.x);
        lo_y = smin(smin(tri_q.a.y, tri_q.b.y), tri_q.c.y);
        hi_y = smax(smax(tri_q.a.y, tri_q.b.y), tri_q.c.y);
        bx_min = smax(ZERO, lo_x);
        bx_max = smin(X_HI, hi_x);
        by_min = smax(ZERO, lo_y);
        by_max = smin(Y_HI, hi_y);
        box_empty = (bx_min > bx_max) || (by_min > by_max);
    end

    // Walk control: the cursor moves only while the output register can take a result.
    always_comb begin
        accept   = (state == S_IDLE) && in_valid;
        out_free = !out_valid || out_ready;
        advance  = (state == S_SCAN) && !scan_last && out_free;
        last_px  = (cx == xmax) && (cy == ymax);
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // FSM next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (in_valid) state_next = S_SETUP;
            S_SETUP: state_next = box_empty ? S_DONE : S_SCAN;
            S_SCAN:  if (scan_last && out_free) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // FSM outputs.
    always_comb begin
        in_ready  = (state == S_IDLE);
        done      = (state == S_DONE);
        dbg_state = state;
    end

    // Triangle capture, box setup and raster cursor.
    always_ff @(posedge clk) begin
        if (rst) begin
            tri_q     <= '0;
            xmin      <= ZERO;
            xmax      <= ZERO;
            ymin      <= ZERO;
            ymax      <= ZERO;
            cx        <= ZERO;
            cy        <= ZERO;
            scan_last <= 1'b0;
        end else begin
            if (accept) begin
                tri_q     <= in_tri;
                scan_last <= 1'b0;
            end
            if (state == S_SETUP) begin
                xmin      <= bx_min;
                xmax      <= bx_max;
                ymin      <= by_min;
                ymax      <= by_max;
                cx        <= bx_min;
                cy        <= by_min;
                scan_last <= 1'b0;
            end
            if (advance) begin
                if (cx == xmax) begin
                    cx <= xmin;
                    cy <= cy + ONE;
                end else begin
                    cx <= cx + ONE;
                end
                if (last_px) scan_last <= 1'b1;
            end
        end
    end

    // Output register: loads a covered pixel on advance, otherwise drains on consume.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_pt    <= '0;
        end else if (advance) begin
            out_valid <= hit;
            if (hit) out_pt <= cursor;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

`ifdef TRI_RASTER_STATS_EN
    // Per-triangle counters: clear on accept, count on each advance, hold after done.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_tested <= 32'd0;
            stat_drawn  <= 32'd0;
        end else if (accept) begin
            stat_tested <= 32'd0;
            stat_drawn  <= 32'd0;
        end else if (advance) begin
            stat_tested <= stat_tested + 32'd1;
            stat_drawn  <= stat_drawn + {31'd0, hit};
        end
    end
`endif
endmodule

// File: tb/tb_tri_raster_scanner.sv
// Bench for tri_raster_scanner. Expected pixel streams come from a geometric
// model: clamp the bounding box, scan it row by row, keep pixels that lie in
// the closed counter-clockwise triangle. Build with TRI_RASTER_STATS_EN to
// also check the statistics counters.
module tb_tri_raster_scanner;
    import tri_raster_pkg::*;

    localparam int SW = 640;
    localparam int SH = 480;
    localparam int RUN_BUDGET = 20000;

    logic      clk = 1'b0;
    logic      rst;
    triangle_t in_tri;
    logic      in_valid;
    logic      in_ready;
    point_t    out_pt;
    logic      out_valid;
    logic      out_ready;
    logic      done;
    logic [1:0] dbg_state;
`ifdef TRI_RASTER_STATS_EN
    logic [31:0] stat_tested;
    logic [31:0] stat_drawn;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    // Clock and DUT.
    always #5 clk = ~clk;

    tri_raster_scanner #(.SCREEN_W(SW), .SCREEN_H(SH)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_tri      (in_tri),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_pt      (out_pt),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .done        (done),
`ifdef TRI_RASTER_STATS_EN
        .stat_tested (stat_tested),
        .stat_drawn  (stat_drawn),
`endif
        .dbg_state   (dbg_state)
    );

    // ---------------- reference model ----------------
    function automatic int imin(input int p, input int q);
        return (p < q) ? p : q;
    endfunction

    function automatic int imax(input int p, input int q);
        return (p > q) ? p : q;
    endfunction

    // Twice the signed area of (p0,p1,p2); positive means counter-clockwise.
    function automatic longint orient(input longint x0, input longint y0, input longint x1,
                                      input longint y1, input longint x2, input longint y2);
        return (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
    endfunction

    function automatic triangle_t mk_tri(input int ax, input int ay, input int bx,
                                         input int by, input int cx, input int cy);
        triangle_t t;
        t.a.x = coord_t'(ax); t.a.y = coord_t'(ay);
        t.b.x = coord_t'(bx); t.b.y = coord_t'(by);
        t.c.x = coord_t'(cx); t.c.y = coord_t'(cy);
        return t;
    endfunction

    // Fills exp_q with the covered pixels in raster order; returns box area and coverage.
    task automatic build_expected(input triangle_t t, output int area, output int ncov);
        int ax, ay, bx, by, cx, cy, xlo, xhi, ylo, yhi;
        longint ar;
        ax = int'(t.a.x); ay = int'(t.a.y);
        bx = int'(t.b.x); by = int'(t.b.y);
        cx = int'(t.c.x); cy = int'(t.c.y);
        xlo = imax(0, imin(imin(ax, bx), cx));
        xhi = imin(SW - 1, imax(imax(ax, bx), cx));
        ylo = imax(0, imin(imin(ay, by), cy));
        yhi = imin(SH - 1, imax(imax(ay, by), cy));
        exp_q.delete();
        area = 0;
        ncov = 0;
        ar = orient(ax, ay, bx, by, cx, cy);
        if (xlo <= xhi && ylo <= yhi) begin
            area = (xhi - xlo + 1) * (yhi - ylo + 1);
            for (int y = ylo; y <= yhi; y++) begin
                for (int x = xlo; x <= xhi; x++) begin
                    if (ar > 0 && orient(ax, ay, bx, by, x, y) >= 0 &&
                        orient(bx, by, cx, cy, x, y) >= 0 &&
                        orient(cx, cy, ax, ay, x, y) >= 0) begin
                        exp_q.push_back({16'(x), 16'(y)});
                        ncov++;
                    end
                end
            end
        end
    endtask

    // ---------------- driver / scoreboard ----------------
    // mode 0: out_ready always 1; mode 1: random out_ready;
    // mode 2: out_ready low for 10 cycles starting at the first out_valid.
    // Called at a negedge; returns at the negedge just after the done pulse.
    task automatic run_tri(input triangle_t t, input int mode, input string name,
                           output int n_out);
        int area, ncov, tc, done_t, stall_left, wait_n, exp_lat;
        bit seen_first;
        logic [31:0] e;
        build_expected(t, area, ncov);
        n_out = 0;
        wait_n = 0;
        while (in_ready !== 1'b1 && wait_n < 50) begin
            @(negedge clk);
            wait_n++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s idle_wait: in_ready=%b required 1", name, in_ready);
            return;
        end
        in_tri = t;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        tc = 0;
        done_t = -1;
        stall_left = 0;
        seen_first = 1'b0;
        while (done_t < 0 && tc < RUN_BUDGET) begin
            checks++;
            if (done === 1'b1 && out_valid === 1'b1) begin
                failures++;
                $display("FAIL %s done_with_valid: both high at cycle %0d", name, tc);
            end
            if (done !== 1'b1) begin
                checks++;
                if (in_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL %s busy_in_ready: in_ready=%b required 0 at cycle %0d",
                             name, in_ready, tc);
                end
            end
            if (done === 1'b1) begin
                done_t = tc;
            end else begin
                if (mode == 2 && out_valid === 1'b1 && !seen_first) begin
                    seen_first = 1'b1;
                    stall_left = 10;
                end
                if (stall_left > 0) begin
                    out_ready = 1'b0;
                    stall_left--;
                    e = (exp_q.size() > 0) ? exp_q[0] : 32'hffff_ffff;
                    checks++;
                    if (out_valid !== 1'b1 || {out_pt.x, out_pt.y} !== e) begin
                        failures++;
                        $display("FAIL %s stall_hold: valid=%b pt=(%0d,%0d) required valid=1 pt=(%0d,%0d)",
                                 name, out_valid, out_pt.x, out_pt.y,
                                 $signed(e[31:16]), $signed(e[15:0]));
                    end
                end else begin
                    out_ready = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
                end
                if (out_valid === 1'b1 && out_ready === 1'b1) begin
                    n_out++;
                    checks++;
                    if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL %s extra_output: got (%0d,%0d) required none",
                                 name, out_pt.x, out_pt.y);
                    end else begin
                        e = exp_q.pop_front();
                        if ({out_pt.x, out_pt.y} !== e) begin
                            failures++;
                            $display("FAIL %s out_pt: got (%0d,%0d) required (%0d,%0d)",
                                     name, out_pt.x, out_pt.y,
                                     $signed(e[31:16]), $signed(e[15:0]));
                        end
                    end
                end
            end
            @(negedge clk);
            tc++;
        end
        checks++;
        if (done_t < 0) begin
            failures++;
            $display("FAIL %s timeout: no done within %0d cycles", name, RUN_BUDGET);
            return;
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL %s missing_outputs: %0d outputs not produced", name, exp_q.size());
        end
        if (mode == 0) begin
            // Non-empty box: SETUP + one cycle per pixel + one drain cycle.
            // Empty box: SETUP then straight to DONE.
            exp_lat = (area > 0) ? area + 2 : 1;
            checks++;
            if (done_t != exp_lat) begin
                failures++;
                $display("FAIL %s done_latency: got %0d required %0d", name, done_t, exp_lat);
            end
        end
`ifdef TRI_RASTER_STATS_EN
        checks++;
        if (stat_tested !== 32'(area) || stat_drawn !== 32'(ncov)) begin
            failures++;
            $display("FAIL %s stats: tested=%0d drawn=%0d required %0d %0d",
                     name, stat_tested, stat_drawn, area, ncov);
        end
`endif
        // One cycle after done: back in IDLE, pulse gone.
        checks++;
        if (done !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL %s after_done: done=%b in_ready=%b required 0 1", name, done, in_ready);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        in_valid = 1'b0;
        in_tri = '0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out_pt !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%b ready=%b done=%b pt=(%0d,%0d) required 0 1 0 (0,0)",
                     out_valid, in_ready, done, out_pt.x, out_pt.y);
        end
`ifdef TRI_RASTER_STATS_EN
        checks++;
        if (stat_tested !== 32'd0 || stat_drawn !== 32'd0) begin
            failures++;
            $display("FAIL reset_stats: %0d %0d required 0 0", stat_tested, stat_drawn);
        end
`endif
        rst = 1'b0;
    endtask

    task automatic test_basic();
        int n;
        run_tri(mk_tri(0, 0, 4, 0, 0, 4), 0, "basic", n);
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL basic_count: got %0d required 15", n);
        end
    endtask

    task automatic test_reversed();
        int n;
        run_tri(mk_tri(0, 0, 0, 4, 4, 0), 0, "reversed", n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL reversed_count: got %0d required 0", n);
        end
    endtask

    task automatic test_offscreen();
        int n;
        run_tri(mk_tri(-10, 0, -2, 0, -10, 8), 0, "offscreen", n);
        checks++;
        if (n != 0) begin
            failures++;
            $display("FAIL offscreen_count: got %0d required 0", n);
        end
    endtask

    task automatic test_stall();
        int n;
        run_tri(mk_tri(0, 0, 4, 0, 0, 4), 2, "stall", n);
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL stall_count: got %0d required 15", n);
        end
    endtask

    task automatic test_screen_edge();
        int n;
        run_tri(mk_tri(630, 470, 700, 470, 630, 520), 0, "screen_edge", n);
    endtask

    task automatic test_reset_mid_scan();
        int area, ncov, w, n;
        build_expected(mk_tri(0, 0, 4, 0, 0, 4), area, ncov);
        in_tri = mk_tri(0, 0, 4, 0, 0, 4);
        in_valid = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        w = 0;
        while (out_valid !== 1'b1 && w < 50) begin
            @(negedge clk);
            w++;
        end
        checks++;
        if (out_valid !== 1'b1) begin
            failures++;
            $display("FAIL midscan_pending: out_valid=%b required 1", out_valid);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0 || out_pt !== '0) begin
            failures++;
            $display("FAIL midscan_reset: valid=%b ready=%b done=%b pt=(%0d,%0d) required 0 1 0 (0,0)",
                     out_valid, in_ready, done, out_pt.x, out_pt.y);
        end
        rst = 1'b0;
        exp_q.delete();
        run_tri(mk_tri(0, 0, 4, 0, 0, 4), 0, "after_reset", n);
        checks++;
        if (n != 15) begin
            failures++;
            $display("FAIL after_reset_count: got %0d required 15", n);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_tri(mk_tri(2, 1, 9, 3, 3, 7), 0, "b2b_first", n);
        run_tri(mk_tri(5, 5, 1, 8, 1, 2), 0, "b2b_second", n);
        repeat (3) @(negedge clk);
        run_tri(mk_tri(0, 0, 3, 0, 0, 3), 1, "after_gap", n);
    endtask

    task automatic test_random();
        int n, bx, by, mode;
        int v[6];
        for (int k = 0; k < 16; k++) begin
            bx = ($urandom_range(0, 3) == 0) ? 620 : 0;
            by = ($urandom_range(0, 3) == 0) ? 460 : 0;
            for (int j = 0; j < 6; j++) begin
                v[j] = int'($urandom_range(0, 26)) - 6 + ((j % 2 == 0) ? bx : by);
            end
            mode = int'($urandom_range(0, 1));
            run_tri(mk_tri(v[0], v[1], v[2], v[3], v[4], v[5]), mode, "random", n);
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        rst = 1'b1;
        in_valid = 1'b0;
        in_tri = '0;
        out_ready = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_reversed();
        test_offscreen();
        test_stall();
        test_screen_edge();
        test_reset_mid_scan();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
